fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_out_stage.sv | 35 +++
 rtl/fetch_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;
  localparam int PC_STEP     = 4;

  localparam logic [INSTR_W_DEF-1:0] HALT_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Word-aligned view of an address: the low two bits never reach the PC.
  function automatic logic [ADDR_W_DEF-1:0] word_align(input logic [ADDR_W_DEF-1:0] a);
    return a & ~ADDR_W_DEF'(3);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch controller bus: ROM port, control inputs and the output valid/ready channel.
interface fetch_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
  parameter int INSTR_W = fetch_pkg::INSTR_W_DEF,
  parameter int CNT_W   = fetch_pkg::CNT_W_DEF
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, halted, fetch_count,
    input  imem_rdata, stall, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, halted, fetch_count,
    output imem_rdata, stall, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_out_stage.sv
// Single output register with valid/ready handshake; flush drops the held entry.
module fetch_out_stage #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
  parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  // Push wins over a same-cycle transfer: the register refills in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_pc    <= push_pc;
      out_instr <= push_instr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect/flush, halt detection, fetch counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                CNT_W    = CNT_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              can_push;
  logic              halt_hit;
  logic              push;

  assign redirect     = bus.redirect_valid;
  assign redirect_tgt = bus.redirect_pc & ~ADDR_W'(3);

  // A halt word is detected exactly where a push would otherwise happen.
  assign can_push = (state_q == ST_FETCH) && !bus.stall && !redirect &&
                    (!out_valid || bus.out_ready);
  assign halt_hit = can_push && (bus.imem_rdata == INSTR_W'(HALT_INSTR));
  assign push     = can_push && !halt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (push && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = ST_FLUSH;
      pc_d    = redirect_tgt;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_FETCH;
        ST_FETCH: begin
          if (halt_hit)  state_d = ST_HALTED;
          else if (push) pc_d    = pc_q + ADDR_W'(PC_STEP);
        end
        ST_FLUSH:  state_d = ST_FETCH;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  fetch_out_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (bus.imem_rdata),
    .out_ready  (bus.out_ready),
    .out_valid  (out_valid),
    .out_pc     (bus.out_pc),
    .out_instr  (bus.out_instr)
  );

  assign bus.out_valid   = out_valid;
  assign bus.imem_addr   = pc_q;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.fetch_count = cnt_q;

endmodule
